jtag_tap_target: RTL and testbench

JTAG_TAP_TARGET -- requirements
Module: jtag_tap_target

---
 rtl/jtag_tap_target.sv | 155 +++++++++++++++
 tb/tb_jtag_tap_target.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_target.sv
// IEEE 1149.1 style TAP target clocked directly by TCK (clk).
// Holds a TAP state machine, an instruction register, a one-bit bypass
// register and a shared data shift register that serves either the user
// register or the boundary-scan chain, depending on the latched instruction.
module jtag_tap_target #(
  parameter int INSTR_WIDTH  = 5,
  parameter int VECTOR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tms,
  input  logic                    tdi,
  output logic                    tdo,
  output logic                    tdoEnable,
  output logic [3:0]              tapState,
  output logic [INSTR_WIDTH-1:0]  instruction,
  output logic [VECTOR_WIDTH-1:0] userReg,
  input  logic [VECTOR_WIDTH-1:0] bsIn,
  output logic [VECTOR_WIDTH-1:0] bsOut,
  output logic                    updateDrPulse
);

  localparam logic [3:0] ST_RESET      = 4'd0;
  localparam logic [3:0] ST_IDLE       = 4'd1;
  localparam logic [3:0] ST_DR_SCAN    = 4'd2;
  localparam logic [3:0] ST_IR_SCAN    = 4'd3;
  localparam logic [3:0] ST_CAPTURE_IR = 4'd4;
  localparam logic [3:0] ST_SHIFT_IR   = 4'd5;
  localparam logic [3:0] ST_EXIT1_IR   = 4'd6;
  localparam logic [3:0] ST_PAUSE_IR   = 4'd7;
  localparam logic [3:0] ST_EXIT2_IR   = 4'd8;
  localparam logic [3:0] ST_UPDATE_IR  = 4'd9;
  localparam logic [3:0] ST_CAPTURE_DR = 4'd10;
  localparam logic [3:0] ST_SHIFT_DR   = 4'd11;
  localparam logic [3:0] ST_EXIT1_DR   = 4'd12;
  localparam logic [3:0] ST_PAUSE_DR   = 4'd13;
  localparam logic [3:0] ST_EXIT2_DR   = 4'd14;
  localparam logic [3:0] ST_UPDATE_DR  = 4'd15;

  // Opcodes are defined on five bits; shorter IRs use the low bits.
  localparam logic [INSTR_WIDTH-1:0] OP_USER = INSTR_WIDTH'(5'b00001);
  localparam logic [INSTR_WIDTH-1:0] OP_BS   = INSTR_WIDTH'(5'b00110);

  logic [3:0]              state;
  logic [3:0]              state_next;
  logic [INSTR_WIDTH-1:0]  ir_sr;
  logic [VECTOR_WIDTH-1:0] dr_sr;
  logic                    byp;
  logic                    sel_user;
  logic                    sel_bs;
  logic                    sel_bypass;

  // Instruction decode: anything unrecognised falls back to bypass.
  always_comb begin
    sel_user   = (instruction == OP_USER);
    sel_bs     = (instruction == OP_BS);
    sel_bypass = !(sel_user || sel_bs);
  end

  // TAP next-state function driven by tms.
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:      state_next = tms ? ST_RESET      : ST_IDLE;
      ST_IDLE:       state_next = tms ? ST_DR_SCAN    : ST_IDLE;
      ST_DR_SCAN:    state_next = tms ? ST_IR_SCAN    : ST_CAPTURE_DR;
      ST_IR_SCAN:    state_next = tms ? ST_RESET      : ST_CAPTURE_IR;
      ST_CAPTURE_IR: state_next = tms ? ST_EXIT1_IR   : ST_SHIFT_IR;
      ST_SHIFT_IR:   state_next = tms ? ST_EXIT1_IR   : ST_SHIFT_IR;
      ST_EXIT1_IR:   state_next = tms ? ST_UPDATE_IR  : ST_PAUSE_IR;
      ST_PAUSE_IR:   state_next = tms ? ST_EXIT2_IR   : ST_PAUSE_IR;
      ST_EXIT2_IR:   state_next = tms ? ST_UPDATE_IR  : ST_SHIFT_IR;
      ST_UPDATE_IR:  state_next = tms ? ST_DR_SCAN    : ST_IDLE;
      ST_CAPTURE_DR: state_next = tms ? ST_EXIT1_DR   : ST_SHIFT_DR;
      ST_SHIFT_DR:   state_next = tms ? ST_EXIT1_DR   : ST_SHIFT_DR;
      ST_EXIT1_DR:   state_next = tms ? ST_UPDATE_DR  : ST_PAUSE_DR;
      ST_PAUSE_DR:   state_next = tms ? ST_EXIT2_DR   : ST_PAUSE_DR;
      ST_EXIT2_DR:   state_next = tms ? ST_UPDATE_DR  : ST_SHIFT_DR;
      ST_UPDATE_DR:  state_next = tms ? ST_DR_SCAN    : ST_IDLE;
      default:       state_next = ST_RESET;
    endcase
  end

  // TAP state register; the reset port overrides tms.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RESET;
    else       state <= state_next;
  end

  // IR shift register: capture the fixed ...0001 pattern, shift right from tdi.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_sr <= '0;
    end else begin
      case (state)
        ST_CAPTURE_IR: ir_sr <= INSTR_WIDTH'(1);
        ST_SHIFT_IR:   ir_sr <= {tdi, ir_sr[INSTR_WIDTH-1:1]};
        default:       ir_sr <= ir_sr;
      endcase
    end
  end

  // Instruction latch: loaded in UpdateIr, cleared whenever the TAP enters Reset.
  always_ff @(posedge clk) begin
    if (reset)                        instruction <= '0;
    else if (state_next == ST_RESET)  instruction <= '0;
    else if (state == ST_UPDATE_IR)   instruction <= ir_sr;
  end

  // Data shift registers: bypass bit or the shared user/boundary-scan chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_sr <= '0;
      byp   <= 1'b0;
    end else begin
      case (state)
        ST_CAPTURE_DR: begin
          byp <= 1'b0;
          if (sel_user)    dr_sr <= userReg;
          else if (sel_bs) dr_sr <= bsIn;
        end
        ST_SHIFT_DR: begin
          if (sel_bypass) byp   <= tdi;
          else            dr_sr <= {tdi, dr_sr[VECTOR_WIDTH-1:1]};
        end
        default: begin
          dr_sr <= dr_sr;
          byp   <= byp;
        end
      endcase
    end
  end

  // Update latches: only the selected target is written in UpdateDr.
  always_ff @(posedge clk) begin
    if (reset) begin
      userReg <= '0;
      bsOut   <= '0;
    end else if (state == ST_UPDATE_DR) begin
      if (sel_user)    userReg <= dr_sr;
      else if (sel_bs) bsOut   <= dr_sr;
    end
  end

  // Serial output path and status flags, all decoded from the current state.
  always_comb begin
    tapState      = state;
    tdoEnable     = (state == ST_SHIFT_IR) || (state == ST_SHIFT_DR);
    updateDrPulse = (state == ST_UPDATE_DR);
    tdo           = 1'b0;
    if (state == ST_SHIFT_IR)      tdo = ir_sr[0];
    else if (state == ST_SHIFT_DR) tdo = sel_bypass ? byp : dr_sr[0];
  end

endmodule

// File: tb/tb_jtag_tap_target.sv
// Directed testbench for jtag_tap_target with default parameters (IR 5, DR 32).
module tb_jtag_tap_target;

  logic        clk;
  logic        reset;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic        tdoEnable;
  logic [3:0]  tapState;
  logic [4:0]  instruction;
  logic [31:0] userReg;
  logic [31:0] bsIn;
  logic [31:0] bsOut;
  logic        updateDrPulse;

  int n_checks = 0;
  int n_pass   = 0;

  jtag_tap_target #(.INSTR_WIDTH(5), .VECTOR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .tms(tms), .tdi(tdi), .tdo(tdo),
    .tdoEnable(tdoEnable), .tapState(tapState), .instruction(instruction),
    .userReg(userReg), .bsIn(bsIn), .bsOut(bsOut), .updateDrPulse(updateDrPulse)
  );

  always #5 clk = ~clk;

  // One TCK cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge clk);
    #1;
  endtask

  task automatic goto_idle();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From Idle: load an instruction and return to Idle.
  task automatic load_ir(input logic [4:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(i == 4, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From Idle: full 32-bit DR scan, collecting tdo, pulses and tdoEnable status.
  task automatic shift_dr(input logic [31:0] d, output logic [31:0] out,
                          output int pulses, output bit en_ok);
    pulses = 0;
    en_ok  = 1'b1;
    out    = '0;
    step(1'b1, 1'b0); pulses += int'(updateDrPulse);
    step(1'b0, 1'b0); pulses += int'(updateDrPulse);
    step(1'b0, 1'b0); pulses += int'(updateDrPulse);
    for (int i = 0; i < 32; i++) begin
      out[i] = tdo;
      if (tdoEnable !== 1'b1) en_ok = 1'b0;
      step(i == 31, d[i]);
      pulses += int'(updateDrPulse);
    end
    step(1'b1, 1'b0); pulses += int'(updateDrPulse);
    step(1'b0, 1'b0); pulses += int'(updateDrPulse);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    reset = 1'b0;
    n_checks++; if (tapState !== 4'd0) $display("FAIL reset_state: got %0d expected 0", tapState); else n_pass++;
    n_checks++; if (instruction !== 5'd0) $display("FAIL reset_instr: got %h expected 00", instruction); else n_pass++;
    n_checks++; if (userReg !== 32'd0) $display("FAIL reset_user: got %h expected 0", userReg); else n_pass++;
    n_checks++; if (bsOut !== 32'd0) $display("FAIL reset_bsout: got %h expected 0", bsOut); else n_pass++;
    n_checks++; if ({tdo, tdoEnable, updateDrPulse} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {tdo, tdoEnable, updateDrPulse}); else n_pass++;
  endtask

  task automatic test_idle_tms_reset();
    step(1'b0, 1'b0);
    n_checks++; if (tapState !== 4'd1) $display("FAIL idle_entry: got %0d expected 1", tapState); else n_pass++;
    repeat (5) step(1'b1, 1'b0);
    n_checks++; if (tapState !== 4'd0) $display("FAIL five_tms_reset: got %0d expected 0", tapState); else n_pass++;
    n_checks++; if (instruction !== 5'd0) $display("FAIL five_tms_instr: got %h expected 00", instruction); else n_pass++;
  endtask

  task automatic test_fsm_walk();
    int walk_tms[28] = '{0,1,0,1,0,1,1,1,1,0,0,1,0,1,0,1,1,1,1,1,1, 0,1,0,0,1,1,0};
    int walk_st[28]  = '{1,2,10,12,13,14,15,2,3,4,5,6,7,8,5,6,9,2,3,0,0, 1,2,10,11,12,15,1};
    logic en_exp;
    repeat (5) step(1'b1, 1'b0);
    for (int i = 0; i < 28; i++) begin
      step(walk_tms[i] != 0, 1'b0);
      en_exp = (walk_st[i] == 5) || (walk_st[i] == 11);
      n_checks++;
      if (tapState !== 4'(walk_st[i])) $display("FAIL walk_state[%0d]: got %0d expected %0d", i, tapState, walk_st[i]);
      else n_pass++;
      n_checks++;
      if (tdoEnable !== en_exp || updateDrPulse !== (walk_st[i] == 15))
        $display("FAIL walk_flags[%0d]: got en=%b pulse=%b expected en=%b pulse=%b", i, tdoEnable, updateDrPulse, en_exp, walk_st[i] == 15);
      else n_pass++;
    end
  endtask

  task automatic test_ir_load();
    logic [4:0] v     = 5'b00110;
    logic [4:0] exp_o = 5'b00001;
    goto_idle();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_checks++; if (tapState !== 4'd5) $display("FAIL ir_shift_state: got %0d expected 5", tapState); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (tdo !== exp_o[i] || tdoEnable !== 1'b1)
        $display("FAIL ir_tdo[%0d]: got tdo=%b en=%b expected tdo=%b en=1", i, tdo, tdoEnable, exp_o[i]);
      else n_pass++;
      step(i == 4, v[i]);
    end
    step(1'b1, 1'b0);
    n_checks++; if (tapState !== 4'd9 || instruction !== 5'd0) $display("FAIL ir_update_cycle: got st=%0d instr=%h expected st=9 instr=00", tapState, instruction); else n_pass++;
    step(1'b0, 1'b0);
    n_checks++; if (instruction !== 5'b00110) $display("FAIL ir_loaded: got %h expected 06", instruction); else n_pass++;
  endtask

  task automatic test_user_reg();
    logic [31:0] out;
    int pulses;
    bit en_ok;
    goto_idle();
    load_ir(5'b00001);
    n_checks++; if (instruction !== 5'b00001) $display("FAIL user_instr: got %h expected 01", instruction); else n_pass++;
    shift_dr(32'hA5A5A5A5, out, pulses, en_ok);
    n_checks++; if (userReg !== 32'hA5A5A5A5) $display("FAIL user_write: got %h expected a5a5a5a5", userReg); else n_pass++;
    n_checks++; if (pulses !== 1) $display("FAIL user_pulse: got %0d expected 1", pulses); else n_pass++;
    n_checks++; if (en_ok !== 1'b1) $display("FAIL user_tdo_enable: got %b expected 1", en_ok); else n_pass++;
    shift_dr(32'h0, out, pulses, en_ok);
    n_checks++; if (out !== 32'hA5A5A5A5) $display("FAIL user_readback: got %h expected a5a5a5a5", out); else n_pass++;
    n_checks++; if (userReg !== 32'h0) $display("FAIL user_rewrite: got %h expected 0", userReg); else n_pass++;
  endtask

  task automatic test_boundary_scan();
    logic [31:0] out;
    int pulses;
    bit en_ok;
    goto_idle();
    load_ir(5'b00110);
    bsIn = 32'h12345678;
    shift_dr(32'h0, out, pulses, en_ok);
    n_checks++; if (out !== 32'h12345678) $display("FAIL bs_capture: got %h expected 12345678", out); else n_pass++;
    n_checks++; if (bsOut !== 32'h0) $display("FAIL bs_update_zero: got %h expected 0", bsOut); else n_pass++;
    n_checks++; if (pulses !== 1) $display("FAIL bs_pulse: got %0d expected 1", pulses); else n_pass++;
    bsIn = 32'h0;
    shift_dr(32'hDEADBEEF, out, pulses, en_ok);
    n_checks++; if (bsOut !== 32'hDEADBEEF) $display("FAIL bs_update: got %h expected deadbeef", bsOut); else n_pass++;
    n_checks++; if (userReg !== 32'h0) $display("FAIL bs_user_untouched: got %h expected 0", userReg); else n_pass++;
  endtask

  task automatic test_bypass();
    logic [3:0] pat   = 4'b1101;
    logic [3:0] exp_o = 4'b1010;
    goto_idle();
    load_ir(5'b11111);
    n_checks++; if (instruction !== 5'b11111) $display("FAIL byp_instr: got %h expected 1f", instruction); else n_pass++;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tdo !== exp_o[i]) $display("FAIL byp_tdo[%0d]: got %b expected %b", i, tdo, exp_o[i]);
      else n_pass++;
      step(i == 3, pat[i]);
    end
    step(1'b1, 1'b0);
    n_checks++; if (updateDrPulse !== 1'b1) $display("FAIL byp_pulse: got %b expected 1", updateDrPulse); else n_pass++;
    step(1'b0, 1'b0);
    n_checks++; if (userReg !== 32'h0 || bsOut !== 32'hDEADBEEF) $display("FAIL byp_no_update: got user=%h bs=%h expected user=0 bs=deadbeef", userReg, bsOut); else n_pass++;
  endtask

  task automatic test_pause_hold();
    logic [31:0] x = 32'hA5A5A5B5;
    logic [31:0] out;
    int pulses;
    bit en_ok;
    goto_idle();
    load_ir(5'b00001);
    shift_dr(x, out, pulses, en_ok);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, 1'b0);
    n_checks++; if (tapState !== 4'd12 || tdo !== 1'b0 || tdoEnable !== 1'b0) $display("FAIL exit1_idle_out: got st=%0d tdo=%b en=%b expected st=12 tdo=0 en=0", tapState, tdo, tdoEnable); else n_pass++;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_checks++; if (tapState !== 4'd13) $display("FAIL pause_state: got %0d expected 13", tapState); else n_pass++;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_checks++; if (tapState !== 4'd11 || tdo !== x[4]) $display("FAIL pause_resume: got st=%0d tdo=%b expected st=11 tdo=%b", tapState, tdo, x[4]); else n_pass++;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    // Five shift cycles in total with tdi=0.
    n_checks++; if (userReg !== (x >> 5)) $display("FAIL pause_result: got %h expected %h", userReg, x >> 5); else n_pass++;
  endtask

  task automatic test_tms_reset_keeps_regs();
    logic [31:0] keep_user;
    keep_user = 32'hA5A5A5B5 >> 5;
    // Idle -> ShiftIr, then five tms=1 samples.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    n_checks++; if (tapState !== 4'd0) $display("FAIL tms_reset_state: got %0d expected 0", tapState); else n_pass++;
    n_checks++; if (instruction !== 5'd0) $display("FAIL tms_reset_instr: got %h expected 00", instruction); else n_pass++;
    n_checks++; if (userReg !== keep_user || bsOut !== 32'hDEADBEEF) $display("FAIL tms_reset_keep: got user=%h bs=%h expected user=%h bs=deadbeef", userReg, bsOut, keep_user); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] out;
    int pulses;
    bit en_ok;
    goto_idle();
    load_ir(5'b00001);
    shift_dr(32'h5A5A0F0F, out, pulses, en_ok);
    n_checks++; if (userReg !== 32'h5A5A0F0F) $display("FAIL mid_preload: got %h expected 5a5a0f0f", userReg); else n_pass++;
    pulses = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      pulses += int'(updateDrPulse);
    end
    n_checks++; if (tapState !== 4'd11) $display("FAIL mid_in_shift: got %0d expected 11", tapState); else n_pass++;
    reset = 1'b1;
    step(1'b1, 1'b1);
    pulses += int'(updateDrPulse);
    reset = 1'b0;
    n_checks++; if (tapState !== 4'd0) $display("FAIL mid_reset_state: got %0d expected 0", tapState); else n_pass++;
    n_checks++; if (userReg !== 32'h0 || bsOut !== 32'h0) $display("FAIL mid_reset_regs: got user=%h bs=%h expected 0", userReg, bsOut); else n_pass++;
    n_checks++; if (instruction !== 5'd0 || tdo !== 1'b0 || tdoEnable !== 1'b0) $display("FAIL mid_reset_out: got instr=%h tdo=%b en=%b expected 0", instruction, tdo, tdoEnable); else n_pass++;
    step(1'b0, 1'b0);
    pulses += int'(updateDrPulse);
    n_checks++; if (pulses !== 0) $display("FAIL mid_no_pulse: got %0d expected 0", pulses); else n_pass++;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    tms   = 1'b1;
    tdi   = 1'b0;
    bsIn  = 32'h0;
    test_reset();
    test_idle_tms_reset();
    test_fsm_walk();
    test_ir_load();
    test_user_reg();
    test_boundary_scan();
    test_bypass();
    test_pause_hold();
    test_tms_reset_keeps_regs();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
